axi4_burst_master: RTL and testbench
====================================

// Module: axi4_burst_master
// PURPOSE
//  Command-driven AXI4 master that turns single write/read burst commands into full
//  AW/W/B or AR/R channel sequences toward the axi4 memory slave. Sits directly
//  upstream of the slave. Bridges a simple cmd / write-stream / read-stream interface
//  to the AXI bus. Exactly one burst is in flight at a time; reads and writes are serialized.
// PARAMETERS
//  DATA_WIDTH  32  WDATA/RDATA width in bits; must be a power of 2, >= 8
//  ADDR_WIDTH  16  AWADDR/ARADDR width in bits
// PORTS
//  ACLK         in   1           clock; all logic on rising edge
//  ARESET       in   1           asynchronous, active-high reset
//  cmd_valid    in   1           command request
//  cmd_ready    out  1           command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1           1 = write burst, 0 = read burst
//  cmd_addr     in   ADDR_WIDTH  byte start address
//  cmd_len      in   8           beats - 1 (AXI LEN encoding)
//  cmd_size     in   3           bytes/beat = 2**cmd_size
//  wd_valid/wd_ready/wd_data  in/out/in  1/1/DATA_WIDTH  write-data stream
//  rd_valid/rd_data/rd_last   out  1/DATA_WIDTH/1        read-data stream; no backpressure
//  done_valid/done_resp/done_err  out  1/2/1    1-cycle completion pulse, response, RLAST error
//  AWADDR/AWLEN/AWSIZE/AWVALID  out  ADDR_WIDTH/8/3/1    write-address channel
//  AWREADY                      in   1
//  WDATA/WLAST/WVALID  out  DATA_WIDTH/1/1;  WREADY  in  1
//  BRESP/BVALID  in  2/1;  BREADY  out  1
//  ARADDR/ARLEN/ARSIZE/ARVALID  out  ADDR_WIDTH/8/3/1;  ARREADY  in  1
//  RDATA/RRESP/RLAST/RVALID  in  DATA_WIDTH/2/1/1;  RREADY  out  1
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE. cmd_ready=1. All VALIDs, BREADY, RREADY,
//   done_valid, done_err and rd_valid are 0. All address/len/size outputs, done_resp,
//   beat counter and sticky response are 0. Reset mid-burst abandons the burst; no done pulse.
//  FSM states: IDLE, AW, W, B, AR, R, REJ. cmd_ready=1 only in IDLE.
//  IDLE: on cmd handshake, register addr/len/size and clear beat_cnt and sticky resp.
//   If cmd_size > log2(DATA_WIDTH/8), go to REJ. Otherwise go to AW if cmd_write, else AR.
//  REJ: done_valid=1, done_resp=2'b10, no bus activity, then IDLE. Latency is 1 cycle after accept.
//  AW: AWVALID=1; AWADDR/AWLEN/AWSIZE are held stable until the AWREADY cycle, then go to W.
//  W: WVALID=wd_valid, WDATA=wd_data, wd_ready=WREADY (combinational, gated by state=W).
//   WLAST=(beat_cnt==len). Each WVALID&WREADY increments beat_cnt.
//   After the beat with WLAST, go to B. Gaps in wd_valid only stall the burst.
//  B: BREADY=1. On BVALID: done_valid=1 (next cycle, registered), done_resp=BRESP, then IDLE.
//  AR: ARVALID=1 with stable fields until ARREADY, then go to R.
//  R: RREADY=1. rd_valid=RVALID, rd_data=RDATA, rd_last=(beat_cnt==len) (combinational).
//   Each beat: beat_cnt++. Sticky resp becomes SLVERR if any RRESP==2'b10 (worst response kept).
//   done_err is set if RLAST != (beat_cnt==len) on any beat.
//   The burst ends on beat beat_cnt==len: done_valid=1, done_resp=sticky resp, then IDLE.
//   RLAST alone never ends the burst early.
//  beat_cnt is 8 bits and is compared to len before incrementing, so len=255 gives 256 beats with no wrap.
//  Addresses are passed through untouched. Range and 4KB-boundary checks belong to the slave;
//   its SLVERR is reported through done_resp.
//  New cmd may be accepted the cycle after done_valid (IDLE). Back-to-back throughput:
//   1 idle cycle/burst.
// TESTING (with axi4 slave, DATA_WIDTH=32, MEMORY_DEPTH=1024)
//  write addr=0x0010 len=3 size=2, wd_data A0..A3 -> 4 W beats, WLAST on 4th only,
//   done_resp=00, done_err=0
//  read addr=0x0010 len=3 size=2 -> rd_data A0,A1,A2,A3, rd_last on 4th only,
//   done_resp=00, done_err=0
//  write addr=0x1000 len=0 (word 1024 out of range) -> single beat, done_resp=10;
//   read same addr -> rd_data=0, done_resp=10
//  cmd_size=3 -> no AWVALID/ARVALID ever; done_valid 1 cycle after accept with done_resp=10
//  wd_valid toggling 1,0,0,1,1,0,1 on len=3 write -> WVALID mirrors it;
//   exactly 4 handshakes; done_resp=00
//  ARESET pulsed while in W after beat 2 of len=7 -> WVALID/AWVALID=0 at once;
//   no done pulse; after release cmd_ready=1 and a new len=0 write completes OK

Source files
------------

// File: rtl/axi4_burst_master.sv
// AXI4 burst master: converts single write/read burst commands into
// AW/W/B or AR/R channel sequences. One burst in flight at a time.
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  // write-data stream
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  // read-data stream
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  // completion
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  // AXI write address
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // AXI write data
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // AXI write response
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // AXI read address
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // AXI read data
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  // Largest legal beat size: one full data word.
  localparam int         LANE_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_REJ
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            beat_q, beat_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  done_valid_q, done_valid_d;
  logic [1:0]            done_resp_q, done_resp_d;
  logic                  done_err_q, done_err_d;

  logic                  beat_last;
  logic [1:0]            rresp_next;
  logic                  rerr_next;

  // Final beat is detected before the counter increments, so len=255 never wraps early.
  assign beat_last = (beat_q == len_q);

  // Worst error response seen so far in the read burst, including the current beat.
  assign rresp_next = (RRESP[1] && (RRESP > resp_q)) ? RRESP : resp_q;
  assign rerr_next  = err_q | (RLAST != beat_last);

  assign cmd_ready  = (state_q == S_IDLE);

  assign AWADDR     = addr_q;
  assign AWLEN      = len_q;
  assign AWSIZE     = size_q;
  assign AWVALID    = (state_q == S_AW);

  assign WVALID     = (state_q == S_W) & wd_valid;
  assign WDATA      = wd_data;
  assign WLAST      = (state_q == S_W) & beat_last;
  assign wd_ready   = (state_q == S_W) & WREADY;

  assign BREADY     = (state_q == S_B);

  assign ARADDR     = addr_q;
  assign ARLEN      = len_q;
  assign ARSIZE     = size_q;
  assign ARVALID    = (state_q == S_AR);

  assign RREADY     = (state_q == S_R);
  assign rd_valid   = (state_q == S_R) & RVALID;
  assign rd_data    = RDATA;
  assign rd_last    = (state_q == S_R) & beat_last;

  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;
  assign done_err   = done_err_q;

  // State and burst context registers; reset abandons any burst in progress.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      beat_q       <= '0;
      resp_q       <= '0;
      err_q        <= 1'b0;
      done_valid_q <= 1'b0;
      done_resp_q  <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      beat_q       <= beat_d;
      resp_q       <= resp_d;
      err_q        <= err_d;
      done_valid_q <= done_valid_d;
      done_resp_q  <= done_resp_d;
      done_err_q   <= done_err_d;
    end
  end

  // Next-state logic: command capture, channel sequencing and completion reporting.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    beat_d       = beat_q;
    resp_d       = resp_q;
    err_d        = err_q;
    done_valid_d = 1'b0;
    done_resp_d  = done_resp_q;
    done_err_d   = done_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          size_d = cmd_size;
          beat_d = '0;
          resp_d = 2'b00;
          err_d  = 1'b0;
          if (cmd_size > MAX_SIZE) begin
            // Oversized beat: report SLVERR without touching the bus.
            state_d      = S_REJ;
            done_valid_d = 1'b1;
            done_resp_d  = 2'b10;
            done_err_d   = 1'b0;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_REJ: state_d = S_IDLE;
      S_AW: begin
        if (AWREADY) state_d = S_W;
      end
      S_W: begin
        if (wd_valid && WREADY) begin
          beat_d = beat_q + 8'd1;
          if (beat_last) state_d = S_B;
        end
      end
      S_B: begin
        if (BVALID) begin
          done_valid_d = 1'b1;
          done_resp_d  = BRESP;
          done_err_d   = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_AR: begin
        if (ARREADY) state_d = S_R;
      end
      S_R: begin
        if (RVALID) begin
          beat_d = beat_q + 8'd1;
          resp_d = rresp_next;
          err_d  = rerr_next;
          if (beat_last) begin
            done_valid_d = 1'b1;
            done_resp_d  = rresp_next;
            done_err_d   = rerr_next;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Testbench for axi4_burst_master: behavioural AXI memory slave plus a
// scoreboard that checks W beats, read-stream beats and completions.
module tb_axi4_burst_master;

  logic        ACLK, ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic        done_valid, done_err;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RLAST, RVALID, RREADY;

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- memory slave model (1024 x 32-bit words) ----------------
  logic [31:0] mem [0:1023];
  logic [15:0] s_waddr, s_raddr, w_cur, r_cur;
  logic [7:0]  s_wcnt, s_rcnt, s_rlen;
  logic        s_werr, s_rbusy, bad_rlast;
  logic        w_oor, r_oor;

  assign AWREADY = 1'b1;
  assign WREADY  = 1'b1;
  assign ARREADY = 1'b1;
  assign w_cur   = s_waddr + {6'b0, s_wcnt, 2'b00};
  assign r_cur   = s_raddr + {6'b0, s_rcnt, 2'b00};
  assign w_oor   = (w_cur[15:12] != 4'd0);
  assign r_oor   = (r_cur[15:12] != 4'd0);
  assign RVALID  = s_rbusy;
  assign RDATA   = r_oor ? 32'd0 : mem[r_cur[11:2]];
  assign RRESP   = r_oor ? 2'b10 : 2'b00;
  assign RLAST   = (s_rcnt == s_rlen) && !bad_rlast;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_waddr <= '0; s_wcnt <= '0; s_werr <= 1'b0;
      s_raddr <= '0; s_rcnt <= '0; s_rlen <= '0; s_rbusy <= 1'b0;
      BVALID  <= 1'b0; BRESP <= 2'b00;
    end else begin
      if (AWVALID && AWREADY) begin
        s_waddr <= AWADDR; s_wcnt <= '0; s_werr <= 1'b0;
      end
      if (WVALID && WREADY) begin
        if (!w_oor) mem[w_cur[11:2]] <= WDATA;
        s_werr <= s_werr | w_oor;
        s_wcnt <= s_wcnt + 8'd1;
        if (WLAST) begin
          BVALID <= 1'b1;
          BRESP  <= (s_werr || w_oor) ? 2'b10 : 2'b00;
        end
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        s_raddr <= ARADDR; s_rlen <= ARLEN; s_rcnt <= '0; s_rbusy <= 1'b1;
      end
      if (RVALID && RREADY) begin
        s_rcnt <= s_rcnt + 8'd1;
        if (s_rcnt == s_rlen) s_rbusy <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { logic [1:0] r; logic e; } done_t;
  beat_t exp_w[$];
  beat_t exp_rd[$];
  done_t exp_done[$];
  beat_t mb;
  done_t md;
  int    errors = 0, checks = 0;
  int    whs = 0, bus_act = 0, done_seen = 0;
  logic [31:0] wbuf [0:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected queues whenever the DUT presents an output.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (AWVALID || ARVALID) bus_act++;
        if (WVALID && WREADY) begin
          whs++;
          if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected: got data %0h expected no beat", WDATA);
          end else begin
            mb = exp_w.pop_front();
            chk("wdata", WDATA, mb.d);
            chk("wlast", WLAST, mb.l);
          end
        end
        if (rd_valid) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got data %0h expected no beat", rd_data);
          end else begin
            mb = exp_rd.pop_front();
            chk("rd_data", rd_data, mb.d);
            chk("rd_last", rd_last, mb.l);
          end
        end
        if (done_valid) begin
          done_seen++;
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got resp %0h expected no pulse", done_resp);
          end else begin
            md = exp_done.pop_front();
            chk("done_resp", done_resp, md.r);
            chk("done_err", done_err, md.e);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l,
                        input logic [2:0] s);
    logic ok;
    ok = 1'b0;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s;
    for (int g = 0; g < 100; g++) begin
      @(negedge ACLK);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept", ok, 1'b1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  // Offers n beats from wbuf; pat gives wd_valid per W-state cycle (all ones past npat).
  task automatic feed_w(input int n, input logic [15:0] pat, input int npat);
    int i, k, g;
    i = 0; k = 0; g = 0;
    wd_valid = (npat > 0) ? pat[0] : 1'b1;
    wd_data  = wbuf[0];
    while (i < n && g < 300) begin
      @(negedge ACLK);
      if (wd_ready) begin
        chk("wvalid_mirror", WVALID, wd_valid);
        if (wd_valid) i++;
        k++;
      end
      g++;
      @(posedge ACLK); #1;
      wd_valid = (i >= n) ? 1'b0 : ((k < npat) ? pat[k] : 1'b1);
      wd_data  = wbuf[i];
    end
    chk("feed_beats", i, n);
  endtask

  task automatic wait_done(input int n0);
    logic ok;
    ok = 1'b0;
    for (int g = 0; g < 200; g++) begin
      @(posedge ACLK);
      if (done_seen > n0) begin ok = 1'b1; break; end
    end
    chk("done_arrived", ok, 1'b1);
  endtask

  task automatic push_w(input int n);
    for (int i = 0; i < n; i++) exp_w.push_back('{d: wbuf[i], l: (i == n - 1)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n0, b0, h0;
    ARESET = 1'b1; bad_rlast = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wd_valid = 1'b0; wd_data = '0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_arvalid", ARVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_bready", BREADY, 1'b0);
    chk("rst_rready", RREADY, 1'b0);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_done_resp", done_resp, 2'b00);
    chk("rst_done_err", done_err, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_awaddr", AWADDR, 16'h0);
    chk("rst_awlen", AWLEN, 8'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // write 4 beats at 0x0010
    wbuf[0] = 32'hA0A0_0000; wbuf[1] = 32'hA1A1_1111;
    wbuf[2] = 32'hA2A2_2222; wbuf[3] = 32'hA3A3_3333;
    push_w(4); exp_done.push_back('{r: 2'b00, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b1, 16'h0010, 8'd3, 3'd2);
    feed_w(4, 16'hFFFF, 0);
    wait_done(n0);

    // read them back
    for (int i = 0; i < 4; i++) exp_rd.push_back('{d: wbuf[i], l: (i == 3)});
    exp_done.push_back('{r: 2'b00, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
    wait_done(n0);

    // out-of-range write and read at 0x1000
    wbuf[0] = 32'h1234_5678;
    push_w(1); exp_done.push_back('{r: 2'b10, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b1, 16'h1000, 8'd0, 3'd2);
    feed_w(1, 16'hFFFF, 0);
    wait_done(n0);
    exp_rd.push_back('{d: 32'h0, l: 1'b1}); exp_done.push_back('{r: 2'b10, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b0, 16'h1000, 8'd0, 3'd2);
    wait_done(n0);

    // oversized beats are rejected with no bus traffic, 1 cycle after accept
    b0 = bus_act;
    exp_done.push_back('{r: 2'b10, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b1, 16'h0010, 8'd0, 3'd3);
    @(negedge ACLK);
    chk("rej_latency", done_valid, 1'b1);
    wait_done(n0);
    exp_done.push_back('{r: 2'b10, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b0, 16'h0010, 8'd2, 3'd7);
    wait_done(n0);
    repeat (2) @(posedge ACLK);
    chk("rej_no_bus", bus_act, b0);

    // stalled write-data stream: pattern 1,0,0,1,1,0,1
    wbuf[0] = 32'hB0B0_0000; wbuf[1] = 32'hB1B1_1111;
    wbuf[2] = 32'hB2B2_2222; wbuf[3] = 32'hB3B3_3333;
    push_w(4); exp_done.push_back('{r: 2'b00, e: 1'b0});
    h0 = whs; n0 = done_seen;
    do_cmd(1'b1, 16'h0040, 8'd3, 3'd2);
    feed_w(4, 16'h0059, 7);
    wait_done(n0);
    chk("toggle_handshakes", whs - h0, 4);

    // slave drops RLAST on the final beat: burst still ends on count, done_err set
    bad_rlast = 1'b1;
    exp_rd.push_back('{d: 32'hA0A0_0000, l: 1'b0});
    exp_rd.push_back('{d: 32'hA1A1_1111, l: 1'b1});
    exp_done.push_back('{r: 2'b00, e: 1'b1});
    n0 = done_seen;
    do_cmd(1'b0, 16'h0010, 8'd1, 3'd2);
    wait_done(n0);
    bad_rlast = 1'b0;

    // reset in the middle of a len=7 write, after two beats
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0C0_0000 + i;
    push_w(8);
    do_cmd(1'b1, 16'h0100, 8'd7, 3'd2);
    feed_w(2, 16'hFFFF, 0);
    wd_valid = 1'b1; wd_data = wbuf[2];
    @(negedge ACLK);
    chk("pre_rst_wvalid", WVALID, 1'b1);
    #1 ARESET = 1'b1;
    #1;
    chk("rst_mid_wvalid", WVALID, 1'b0);
    chk("rst_mid_awvalid", AWVALID, 1'b0);
    chk("rst_mid_done", done_valid, 1'b0);
    wd_valid = 1'b0;
    exp_w.delete();
    n0 = done_seen;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    repeat (3) @(posedge ACLK);
    chk("rst_no_done", done_seen, n0);
    @(negedge ACLK);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // recovery write
    wbuf[0] = 32'hD0D0_D0D0;
    push_w(1); exp_done.push_back('{r: 2'b00, e: 1'b0});
    n0 = done_seen;
    do_cmd(1'b1, 16'h0020, 8'd0, 3'd2);
    feed_w(1, 16'hFFFF, 0);
    wait_done(n0);

    repeat (5) @(posedge ACLK);
    chk("left_w", exp_w.size(), 0);
    chk("left_rd", exp_rd.size(), 0);
    chk("left_done", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
